// File: rtl/debouncer.sv
// debouncer: removes contact bounce from a mechanical switch input.
//
// The raw input is sampled once per tick of a free-running divider. A change
// of level is accepted only after STABLE_CNT consecutive ticks during which
// the input held its new value. Any revert during that window discards the
// change. Outputs are a registered debounced level (db_level) and a
// single-cycle pulse (db_tick) on every accepted rising edge.
//
// Build option: define DEBOUNCER_SYNC_EN to insert a 2-flop synchronizer in
// front of the filter. Use this when sw is not already synchronous to clk.
// This adds two cycles to every latency. The default build omits it.
//
// Handshake: none. sw is a free-running level input. db_level is a level
// output. db_tick is a strobe that is valid for exactly one clk cycle with
// no back-pressure.

module debouncer #(
    parameter int TICK_DIV   = 100000,  // clk cycles per sample tick, >= 2
    parameter int STABLE_CNT = 4        // stable ticks to accept a change, >= 1
) (
    input  logic clk,
    input  logic rst,       // synchronous, active low
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] SCNT_LOAD = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] SCNT_ZERO = '0;

    // ------------------------------------------------------------------
    // FSM state encoding
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ZERO  = 2'd0,   // debounced low, input agrees
        WAIT1 = 2'd1,   // debounced low, input high, qualifying the rise
        ONE   = 2'd2,   // debounced high, input agrees
        WAIT0 = 2'd3    // debounced high, input low, qualifying the fall
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   scnt;
    logic [CW-1:0]   scnt_nx;
    logic [TW-1:0]   tick_cnt;
    logic            m_tick;
    logic            sw_s;
    logic            level_nx;
    logic            tick_nx;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef DEBOUNCER_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    // Two-flop synchronizer that brings the asynchronous switch level into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= sw;
            sync_q2 <= sync_q1;
        end
    end

    assign sw_s = sync_q2;
`else
    // The input is already synchronous to clk, so it is used directly.
    assign sw_s = sw;
`endif

    // ------------------------------------------------------------------
    // Sample-tick divider
    // ------------------------------------------------------------------
    // Free-running 0..TICK_DIV-1 counter. It restarts from 0 after every reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_MAX) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign m_tick = (tick_cnt == TICK_MAX);

    // ------------------------------------------------------------------
    // Filter FSM
    // ------------------------------------------------------------------
    // Next-state logic. A revert of sw_s is tested before m_tick, so a revert
    // wins over a tick that would otherwise complete the change.
    always_comb begin
        state_nx = state;
        scnt_nx  = scnt;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_nx = WAIT1;
                    scnt_nx  = SCNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_nx = ZERO;
                end else if (m_tick) begin
                    if (scnt == SCNT_ZERO) begin
                        state_nx = ONE;
                    end else begin
                        scnt_nx = scnt - CW'(1);
                    end
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_nx = WAIT0;
                    scnt_nx  = SCNT_LOAD;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_nx = ONE;
                end else if (m_tick) begin
                    if (scnt == SCNT_ZERO) begin
                        state_nx = ZERO;
                    end else begin
                        scnt_nx = scnt - CW'(1);
                    end
                end
            end
            default: begin
                state_nx = ZERO;
                scnt_nx  = SCNT_ZERO;
            end
        endcase
    end

    // Output decode from the next state. The outputs are registered alongside
    // the state, so they always match the state held in the register.
    always_comb begin
        level_nx = (state_nx == ONE) || (state_nx == WAIT0);
        tick_nx  = (state == WAIT1) && (state_nx == ONE);
    end

    // State, stable counter and output registers. Reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ZERO;
            scnt     <= SCNT_ZERO;
            db_level <= 1'b0;
            db_tick  <= 1'b0;
        end else begin
            state    <= state_nx;
            scnt     <= scnt_nx;
            db_level <= level_nx;
            db_tick  <= tick_nx;
        end
    end

endmodule

// File: tb/tb_debouncer.sv
// tb_debouncer: directed and random stimulus for debouncer.
// Define DEBOUNCER_SYNC_EN for both bench and RTL to exercise the synchronizer build.

module tb_debouncer;

    localparam int TICK_DIV   = 4;
    localparam int STABLE_CNT = 3;
`ifdef DEBOUNCER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sw  = 1'b0;
    logic db_level;
    logic db_tick;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: the accepted level, plus how many sample ticks the
    // input has disagreed with it without interruption.
    int m_cyc     = 0;
    bit m_level   = 1'b0;
    bit m_pending = 1'b0;
    int m_ticks   = 0;
    bit m_rose    = 1'b0;
    bit m_s1      = 1'b0;
    bit m_s2      = 1'b0;

    debouncer #(
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit s, input bit r);
        bit samp;
        bit tick;
        if (!r) begin
            m_cyc = 0; m_level = 0; m_pending = 0; m_ticks = 0;
            m_rose = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            if (SYNC_LAT != 0) begin
                samp = m_s2;
                m_s2 = m_s1;
                m_s1 = s;
            end else begin
                samp = s;
            end
            tick   = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
            m_cyc  = m_cyc + 1;
            m_rose = 0;
            if (samp == m_level) begin
                m_pending = 0;
            end else if (!m_pending) begin
                m_pending = 1;
                m_ticks   = 0;
            end else if (tick) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == STABLE_CNT) begin
                    m_level   = samp;
                    m_pending = 0;
                    m_rose    = samp;
                end
            end
        end
    endtask

    // One clock: drive the inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(input logic s, input logic r, input string tag);
        sw  = s;
        rst = r;
        @(posedge clk);
        model_step(s, r);
        #1;
        check({tag, "_level"}, 32'(db_level), 32'(m_level));
        check({tag, "_tick"},  32'(db_tick),  32'(m_rose));
    endtask

    // Hold sw at val for 40 cycles. Measure when db_level follows and count the db_tick pulses seen.
    task automatic measure(input logic val, input int lo, input int hi,
                           input int exp_ticks, input string tag);
        int lat = -1;
        int nt  = 0;
        for (int n = 1; n <= 40; n++) begin
            step(val, 1'b1, tag);
            if (db_tick === 1'b1) nt++;
            if (lat < 0 && db_level === val) lat = n - 1;
        end
        check({tag, "_lat_in_window"}, 32'(lat >= lo && lat <= hi), 32'd1);
        check({tag, "_tick_count"}, 32'(nt), 32'(exp_ticks));
    endtask

    initial begin
        // Reset held with sw high. The outputs stay low and the FSM stays in ZERO.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, "reset");
            check("reset_state", 32'(dut.state), 32'd0);
        end

        // Clean press from a settled low input.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "idle");
        measure(1'b1, 9 + SYNC_LAT, 12 + SYNC_LAT, 1, "press");

        // Short release glitch while high. The level holds and no pulse appears.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "glitch");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, "glitch_hold");
            check("glitch_level_high", 32'(db_level), 32'd1);
            check("glitch_no_tick", 32'(db_tick), 32'd0);
        end

        // Full release. The level falls and no pulse appears.
        measure(1'b0, 9 + SYNC_LAT, 12 + SYNC_LAT, 0, "release");

        // Bounce: short high bursts are never accepted.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 5; i++) begin
                step(1'b1, 1'b1, "bounce");
                check("bounce_level_low", 32'(db_level), 32'd0);
                check("bounce_no_tick", 32'(db_tick), 32'd0);
            end
            step(1'b0, 1'b1, "bounce");
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, "bounce_tail");
            check("bounce_tail_low", 32'(db_level), 32'd0);
        end

        // Reset part-way through qualifying a press. The press aborts, then qualifies again.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, "pre_rst");
        step(1'b1, 1'b0, "mid_rst");
        check("mid_rst_state", 32'(dut.state), 32'd0);
        check("mid_rst_no_tick", 32'(db_tick), 32'd0);
        measure(1'b1, 9 + SYNC_LAT, 12 + SYNC_LAT, 1, "after_rst");

        // Random runs of sw with occasional reset, checked against the model.
        for (int k = 0; k < 90; k++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            if ($urandom_range(0, 29) == 0) step(v, 1'b0, "rand_rst");
            for (int i = 0; i < len; i++) step(v, 1'b1, "rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000: clk cycles per sample tick; legal range >= 2.
REQ-002 The block SHALL have parameter STABLE_CNT, default 4: consecutive sample ticks of stable input needed to accept a change; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset (rst=0 resets on the next clk rising edge).
REQ-005 The block SHALL have port sw, input, 1 bit: raw, bouncing, asynchronous level from a mechanical switch.
REQ-006 The block SHALL have port db_level, output, 1 bit: debounced level, the clean input for the downstream rising-edge detector.
REQ-007 The block SHALL have port db_tick, output, 1 bit: one-cycle pulse marking each accepted 0->1 change of db_level.

Function
REQ-008 Internal sample signal sw_s SHALL be sw, or its synchronized copy when REQ-024 applies.
REQ-009 A free-running counter of width $clog2(TICK_DIV) SHALL count 0..TICK_DIV-1 and wrap to 0; m_tick SHALL be 1 in the cycle the count equals TICK_DIV-1.
REQ-010 The FSM SHALL have exactly four states: ZERO, WAIT1, ONE, WAIT0, held in a registered state with separate combinational next-state logic.
REQ-011 ZERO: if sw_s=1, go to WAIT1 and load the stable counter scnt with STABLE_CNT-1; otherwise stay in ZERO.
REQ-012 WAIT1: if sw_s=0, return to ZERO with no output activity; else on m_tick go to ONE if scnt=0, otherwise decrement scnt; otherwise hold.
REQ-013 ONE: if sw_s=0, go to WAIT0 and load scnt with STABLE_CNT-1; otherwise stay in ONE.
REQ-014 WAIT0: if sw_s=1, return to ONE; else on m_tick go to ZERO if scnt=0, otherwise decrement scnt; otherwise hold.
REQ-015 If sw_s reverts in the same cycle as m_tick with scnt=0, the revert SHALL win (return to the origin state).
REQ-016 db_level SHALL be a registered (Moore) output: 1 in states ONE and WAIT0, 0 in states ZERO and WAIT1.
REQ-017 db_tick SHALL be 1 for exactly one cycle: the first cycle the state is ONE after entry from WAIT1; never on WAIT0->ONE.
REQ-018 An accepted change SHALL occur on the STABLE_CNT-th m_tick after entry to a WAIT state with sw_s held, giving latency (STABLE_CNT-1)*TICK_DIV+1 to STABLE_CNT*TICK_DIV cycles from sw_s change.
REQ-019 scnt width SHALL be max(1,$clog2(STABLE_CNT)); scnt SHALL never underflow.

Reset
REQ-020 With rst=0 at a clk edge: state=ZERO, tick counter=0, scnt=0, db_level=0, db_tick=0, synchronizer flops=0.
REQ-021 Reset mid-WAIT1 or mid-ONE SHALL abort immediately with no db_tick emitted; reset SHALL override all other inputs.
REQ-022 After rst returns to 1, the tick counter SHALL start from 0 on the first cycle.

Configuration
REQ-023 The macro DEBOUNCER_SYNC_EN SHALL control the input synchronizer.
REQ-024 With DEBOUNCER_SYNC_EN defined: sw SHALL pass through a 2-flop synchronizer, so sw_s lags sw by 2 cycles and all latencies grow by 2.
REQ-025 Without DEBOUNCER_SYNC_EN: sw_s=sw directly, with no added latency; the input is then assumed already synchronous to clk.

Verification (TICK_DIV=4, STABLE_CNT=3, DEBOUNCER_SYNC_EN undefined unless stated)
REQ-026 Reset test: hold rst=0 for 3 cycles with sw=1 -> db_level=0, db_tick=0 throughout; state ZERO.
REQ-027 Clean press: sw 0->1 and held -> db_level rises 9..12 cycles later; db_tick=1 for exactly that one cycle.
REQ-028 Bounce: sw=1 for 5 cycles, 0 for 1 cycle, repeated 4 times, then 0 -> db_level and db_tick stay 0 throughout.
REQ-029 Release glitch: while in ONE, sw=0 for 6 cycles, then 1 -> db_level stays 1 and db_tick stays 0; after a full release, db_level falls 9..12 cycles later with no db_tick.
REQ-030 Reset mid-WAIT1: rst=0 for 1 cycle 6 cycles after press -> no db_tick; with sw still 1, db_level rises 9..12 cycles after rst releases.
REQ-031 With DEBOUNCER_SYNC_EN defined: clean press -> db_level rises 11..14 cycles after the sw change.
